// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the two-requester register-bank arbiter.
package reg_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } arb_state_e;

  localparam int unsigned NUM_REQ         = 2;
  localparam int unsigned DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin winner selection; i_ptr names the requester preferred on a tie.
module rr_pick2 (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_ptr,
  output logic o_gnt,
  output logic o_valid
);

  always_comb begin
    o_valid = i_req0 | i_req1;
    if (i_req0 && i_req1) begin
      o_gnt = i_ptr;
    end else begin
      o_gnt = i_req1;
    end
  end

endmodule

// File: rtl/reg_arbiter.sv
// Arbitrates two requesters onto one register bank: IDLE -> ACCESS -> RESP,
// with round-robin fairness and an access timeout that completes with an error.
module reg_arbiter
  import reg_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned REG_W   = 8,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              ena,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr_rdn0,
  input  logic              wr_rdn1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [REG_W-1:0]  wdata0,
  input  logic [REG_W-1:0]  wdata1,
  output logic              done0,
  output logic              done1,
  output logic [REG_W-1:0]  rdata0,
  output logic [REG_W-1:0]  rdata1,
  output logic              err0,
  output logic              err1,
  output logic              busy,
  output logic              bank_sel,
  output logic              bank_wr_rdn,
  output logic [ADDR_W-1:0] bank_addr,
  output logic [REG_W-1:0]  bank_wdata,
  output logic              bank_we,
  input  logic [REG_W-1:0]  bank_rdata,
  input  logic              bank_ack,
  input  logic              bank_err
);

  localparam int unsigned IdxW       = $clog2(NUM_REQ);
  localparam logic [7:0]  TimeoutLim = 8'(TIMEOUT);

  arb_state_e        r_state;
  logic [IdxW-1:0]   r_gnt;
  logic              r_prio;
  logic [7:0]        r_cnt;
  logic              r_done0;
  logic              r_done1;
  logic [REG_W-1:0]  r_rdata0;
  logic [REG_W-1:0]  r_rdata1;
  logic              r_err0;
  logic              r_err1;
  logic              r_bank_sel;
  logic              r_bank_wr_rdn;
  logic              r_bank_we;
  logic [ADDR_W-1:0] r_bank_addr;
  logic [REG_W-1:0]  r_bank_wdata;

  logic [IdxW-1:0]   w_gnt;
  logic              w_valid;
  logic              w_wr;
  logic [ADDR_W-1:0] w_addr;
  logic [REG_W-1:0]  w_wdata;
  logic [7:0]        w_cnt_nxt;
  logic              w_fin;
  logic [REG_W-1:0]  w_rdata_cap;
  logic              w_err_cap;

  rr_pick2 u_pick (
    .i_req0  (req0),
    .i_req1  (req1),
    .i_ptr   (r_prio),
    .o_gnt   (w_gnt),
    .o_valid (w_valid)
  );

  assign w_wr      = w_gnt[0] ? wr_rdn1 : wr_rdn0;
  assign w_addr    = w_gnt[0] ? addr1   : addr0;
  assign w_wdata   = w_gnt[0] ? wdata1  : wdata0;
  assign w_cnt_nxt = r_cnt + 8'd1;
  // Either the bank answers or this is the last cycle the timeout allows.
  assign w_fin     = bank_ack | (w_cnt_nxt == TimeoutLim);
  assign w_rdata_cap = (bank_ack && !r_bank_wr_rdn) ? bank_rdata : '0;
  assign w_err_cap   = bank_ack ? bank_err : 1'b1;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state       <= StIdle;
      r_gnt         <= '0;
      r_prio        <= 1'b0;
      r_cnt         <= '0;
      r_done0       <= 1'b0;
      r_done1       <= 1'b0;
      r_rdata0      <= '0;
      r_rdata1      <= '0;
      r_err0        <= 1'b0;
      r_err1        <= 1'b0;
      r_bank_sel    <= 1'b0;
      r_bank_wr_rdn <= 1'b0;
      r_bank_we     <= 1'b0;
      r_bank_addr   <= '0;
      r_bank_wdata  <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (ena && w_valid) begin
            r_gnt         <= w_gnt;
            r_cnt         <= '0;
            r_bank_sel    <= 1'b1;
            r_bank_wr_rdn <= w_wr;
            r_bank_we     <= w_wr;
            r_bank_addr   <= w_addr;
            r_bank_wdata  <= w_wdata;
            r_state       <= StAccess;
          end
        end
        StAccess: begin
          if (w_fin) begin
            r_bank_sel    <= 1'b0;
            r_bank_wr_rdn <= 1'b0;
            r_bank_we     <= 1'b0;
            r_bank_addr   <= '0;
            r_bank_wdata  <= '0;
            r_prio        <= ~r_gnt[0];
            if (r_gnt[0]) begin
              r_done1  <= 1'b1;
              r_rdata1 <= w_rdata_cap;
              r_err1   <= w_err_cap;
            end else begin
              r_done0  <= 1'b1;
              r_rdata0 <= w_rdata_cap;
              r_err0   <= w_err_cap;
            end
            r_state <= StResp;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        StResp: begin
          r_done0 <= 1'b0;
          r_done1 <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign done0       = r_done0;
  assign done1       = r_done1;
  assign rdata0      = r_rdata0;
  assign rdata1      = r_rdata1;
  assign err0        = r_err0;
  assign err1        = r_err1;
  assign busy        = (r_state != StIdle);
  assign bank_sel    = r_bank_sel;
  assign bank_wr_rdn = r_bank_wr_rdn;
  assign bank_we     = r_bank_we;
  assign bank_addr   = r_bank_addr;
  assign bank_wdata  = r_bank_wdata;

endmodule

// File: tb/tb_reg_arbiter.sv
// Directed bench for reg_arbiter: inputs change and outputs are sampled on falling edges.
module tb_reg_arbiter;

  logic       clk = 1'b0;
  logic       rstb, ena, req0, req1, wr_rdn0, wr_rdn1;
  logic [7:0] addr0, addr1, wdata0, wdata1, bank_rdata;
  logic       bank_ack, bank_err;
  logic       done0, done1, err0, err1, busy, bank_sel, bank_wr_rdn, bank_we;
  logic [7:0] rdata0, rdata1, bank_addr, bank_wdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  reg_arbiter #(
    .ADDR_W  (8),
    .REG_W   (8),
    .TIMEOUT (4)
  ) dut (
    .clk         (clk),
    .rstb        (rstb),
    .ena         (ena),
    .req0        (req0),
    .req1        (req1),
    .wr_rdn0     (wr_rdn0),
    .wr_rdn1     (wr_rdn1),
    .addr0       (addr0),
    .addr1       (addr1),
    .wdata0      (wdata0),
    .wdata1      (wdata1),
    .done0       (done0),
    .done1       (done1),
    .rdata0      (rdata0),
    .rdata1      (rdata1),
    .err0        (err0),
    .err1        (err1),
    .busy        (busy),
    .bank_sel    (bank_sel),
    .bank_wr_rdn (bank_wr_rdn),
    .bank_addr   (bank_addr),
    .bank_wdata  (bank_wdata),
    .bank_we     (bank_we),
    .bank_rdata  (bank_rdata),
    .bank_ack    (bank_ack),
    .bank_err    (bank_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {24'd0, done0, done1, err0, err1, busy, bank_sel, bank_wr_rdn, bank_we,
            rdata0, rdata1, bank_addr, bank_wdata};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rstb = 1'b1; ena = 1'b0; req0 = 1'b0; req1 = 1'b0;
    wr_rdn0 = 1'b0; wr_rdn1 = 1'b0;
    addr0 = 8'h03; addr1 = 8'h07; wdata0 = 8'h00; wdata1 = 8'hC3;
    bank_rdata = 8'h11; bank_ack = 1'b1; bank_err = 1'b0;
    #1 rstb = 1'b0;
    #1 chk("reset_outs", all_outs(), 64'd0);

    // Contention from reset: 0, then 1, then 0 again.
    cyc(1);
    rstb = 1'b1; ena = 1'b1; req0 = 1'b1; req1 = 1'b1;
    cyc(1);
    chk("cont_busy", 64'(busy), 64'd1);
    chk("cont_addr_first", 64'(bank_addr), 64'h03);
    cyc(1);
    chk("cont_done0_first", 64'(done0), 64'd1);
    chk("cont_done1_first", 64'(done1), 64'd0);
    chk("cont_rdata0", 64'(rdata0), 64'h11);
    cyc(1);
    chk("cont_idle_busy", 64'(busy), 64'd0);
    cyc(1);
    chk("cont_addr_second", 64'(bank_addr), 64'h07);
    cyc(1);
    chk("cont_done1_second", 64'(done1), 64'd1);
    chk("cont_done0_second", 64'(done0), 64'd0);
    chk("cont_rdata1", 64'(rdata1), 64'h11);
    cyc(3);
    chk("cont_done0_third", 64'(done0), 64'd1);
    chk("cont_done1_third", 64'(done1), 64'd0);
    req0 = 1'b0; req1 = 1'b0;
    cyc(1);

    // Single read, immediate ack: done0 two cycles after the grant edge.
    req0 = 1'b1; addr0 = 8'h03; bank_rdata = 8'h5A;
    cyc(1);
    chk("rd_sel", 64'(bank_sel), 64'd1);
    chk("rd_addr", 64'(bank_addr), 64'h03);
    chk("rd_we", 64'(bank_we), 64'd0);
    chk("rd_done_early", 64'(done0), 64'd0);
    cyc(1);
    chk("rd_done0", 64'(done0), 64'd1);
    chk("rd_rdata0", 64'(rdata0), 64'h5A);
    chk("rd_err0", 64'(err0), 64'd0);
    chk("rd_done1", 64'(done1), 64'd0);
    req0 = 1'b0;
    cyc(1);
    chk("rd_pulse_end", 64'(done0), 64'd0);
    chk("rd_hold", 64'(rdata0), 64'h5A);
    chk("rd_idle", {62'd0, busy, bank_sel}, 64'd0);
    chk("rd_addr_zero", 64'(bank_addr), 64'd0);

    // Write from requester 1; read data must come back as zero.
    req1 = 1'b1; wr_rdn1 = 1'b1; addr1 = 8'h07; wdata1 = 8'hC3; bank_rdata = 8'hEE;
    cyc(1);
    chk("wr_bank", {44'd0, bank_sel, bank_we, bank_wr_rdn, 1'b0, bank_addr, bank_wdata},
        {44'd0, 4'b1110, 8'h07, 8'hC3});
    cyc(1);
    chk("wr_done1", 64'(done1), 64'd1);
    chk("wr_rdata1", 64'(rdata1), 64'd0);
    chk("wr_err1", 64'(err1), 64'd0);
    chk("wr_we_once", 64'(bank_we), 64'd0);
    chk("wr_rdata0_hold", 64'(rdata0), 64'h5A);
    req1 = 1'b0; wr_rdn1 = 1'b0;
    cyc(1);

    // Timeout: no ack, four ACCESS cycles; ena drops mid-transaction.
    bank_ack = 1'b0; req0 = 1'b1; addr0 = 8'h20; bank_rdata = 8'h77;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk("to_access", {62'd0, bank_sel, done0}, 64'd2);
      if (i == 1) ena = 1'b0;
    end
    cyc(1);
    chk("to_done0", 64'(done0), 64'd1);
    chk("to_err0", 64'(err0), 64'd1);
    chk("to_rdata0", 64'(rdata0), 64'd0);
    addr0 = 8'h03;

    // Enable gating, then reset in the middle of an access.
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("ena_low_busy", 64'(busy), 64'd0);
    end
    ena = 1'b1;
    cyc(1);
    chk("ena_grant", {62'd0, busy, bank_sel}, 64'd3);
    rstb = 1'b0;
    #1 chk("midreset_outs", all_outs(), 64'd0);
    cyc(1);
    chk("midreset_hold", all_outs(), 64'd0);
    rstb = 1'b1; req1 = 1'b1; bank_ack = 1'b1;
    cyc(1);
    chk("post_reset_winner", 64'(bank_addr), 64'h03);
    cyc(1);
    chk("post_reset_done0", 64'(done0), 64'd1);
    chk("post_reset_done1", 64'(done1), 64'd0);
    req0 = 1'b0; req1 = 1'b0;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reg_arbiter.md
REG_ARBITER -- requirements
Module: reg_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, register address width.
REQ-002 Parameter REG_W, default 8, register data width.
REQ-003 Parameter TIMEOUT, default 15, maximum ACCESS cycles before a forced error completion; legal range 1..255.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rstb  input  1  reset, asynchronous assert, active-low.
REQ-006 ena  input  1  block enable; gates acceptance of new grants only.
REQ-007 req0 / req1  input  1  requester k transaction request; held high until done_k.
REQ-008 wr_rdn0 / wr_rdn1  input  1  1 = write, 0 = read.
REQ-009 addr0 / addr1  input  ADDR_W  target register address.
REQ-010 wdata0 / wdata1  input  REG_W  write data.
REQ-011 done0 / done1  output  1  one-cycle completion pulse to requester k.
REQ-012 rdata0 / rdata1  output  REG_W  read data, valid while done_k is high.
REQ-013 err0 / err1  output  1  error flag, valid while done_k is high.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 bank_sel  output  1  bank access strobe.
REQ-016 bank_wr_rdn  output  1  direction to the bank.
REQ-017 bank_addr  output  ADDR_W  address to the bank.
REQ-018 bank_wdata  output  REG_W  write data to the bank.
REQ-019 bank_we  output  1  bank write enable, equal to bank_sel AND latched wr_rdn.
REQ-020 bank_rdata  input  REG_W  bank read data, sampled on bank_ack.
REQ-021 bank_ack  input  1  bank completion.
REQ-022 bank_err  input  1  bank error, sampled on bank_ack.

Function
REQ-023 The FSM SHALL have states IDLE, ACCESS and RESP.
REQ-024 IDLE: when ena=1 and req0 or req1 is high, the FSM SHALL select a winner, latch its wr_rdn/addr/wdata, and enter ACCESS on the next edge.
REQ-025 Arbitration: if both requests are high, the requester not served last SHALL win; a single request SHALL win unconditionally.
REQ-026 The last-served pointer SHALL update only on entry to RESP.
REQ-027 ACCESS: bank_sel SHALL be high, with bank_addr, bank_wdata and bank_wr_rdn driven from the latched values and held stable.
REQ-028 ACCESS: on bank_ack=1, the block SHALL capture bank_rdata (forced to 0 for writes) and bank_err, then enter RESP.
REQ-029 ACCESS: a cycle counter SHALL start at 0 on entry and increment each ACCESS cycle without ack.
REQ-030 When the counter reaches TIMEOUT with no ack, the block SHALL enter RESP with err=1 and rdata=0.
REQ-031 RESP: done_k SHALL pulse for exactly one cycle for the winner only, with rdata_k/err_k valid; the FSM SHALL then return to IDLE.
REQ-032 Latency: with request seen in IDLE at cycle N and immediate ack, done SHALL be high at cycle N+2.
REQ-033 req_k re-asserted in the cycle after done_k SHALL be arbitrated normally; back-to-back minimum period is 3 cycles.
REQ-034 ena dropping during ACCESS or RESP SHALL NOT abort the transaction; only the next grant is blocked.
REQ-035 rdata_k/err_k SHALL hold their last values when done_k is low; bank outputs SHALL be 0 when bank_sel is low.

Reset
REQ-036 On rstb low, the block SHALL enter IDLE and clear the pointer so requester 0 has priority, and clear the counter and latches.
REQ-037 On rstb low, every output SHALL be 0.
REQ-038 Reset asserted mid-ACCESS SHALL abandon the transaction with no done pulse.

Structure
REQ-039 Package reg_arb_pkg SHALL hold the state enum typedef, NUM_REQ=2, and the default TIMEOUT.
REQ-040 Winner selection SHALL be a sub-module rr_pick2 (inputs: two requests and the pointer; output: grant index and valid).

Verification
REQ-041 Single read: req0, addr=0x03, bank returns 0x5A with immediate ack -> done0 at N+2, rdata0=0x5A, err0=0, done1 never asserted.
REQ-042 Contention: req0 and req1 both high from reset -> requester 0 served first, then requester 1; both high again -> requester 0 served after requester 1.
REQ-043 Write: req1 write addr=0x07 wdata=0xC3 -> exactly one ACCESS cycle with bank_we=1, bank_addr=0x07, bank_wdata=0xC3; done1 with rdata1=0.
REQ-044 Timeout: bank_ack held 0 with TIMEOUT=4 -> done0 with err0=1 and rdata0=0 after 4 ACCESS cycles.
REQ-045 Enable and reset: ena=0 with req0 high -> busy stays 0; ena=1 -> grant; rstb pulsed mid-ACCESS -> all outputs 0, no done, requester 0 has priority.
